// File: rtl/ps2_rx_ctrl.sv
// rtl/ps2_rx_ctrl.sv - PS/2 keyboard receive controller with clock filter, frame FSM and F0/E0 prefix tracking
module ps2_rx_ctrl #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       C,
  input  logic       RST,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [7:0] CODE,
  output logic       VALID,
  output logic       BRK,
  output logic       EXT,
  output logic       ERR,
  output logic       BUSY
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [FW-1:0] FLIM = FW'(FILTER - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    st_idle,
    st_data,
    st_parity,
    st_stop,
    st_done
  } state_t;

  state_t state, next_state;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          fclk, fclk_d;
  logic [FW-1:0] fcnt;
  logic          fe;

  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          brk_pend, ext_pend;

  logic          tmo;
  logic          bad;
  logic          accept;

  // Two-flop synchronizers plus glitch filter on the PS/2 clock; filtered level only moves after FILTER differing samples
  always_ff @(posedge C) begin
    if (RST) begin
      c_s1   <= 1'b1;
      c_s2   <= 1'b1;
      d_s1   <= 1'b1;
      d_s2   <= 1'b1;
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      c_s1   <= PS2C;
      c_s2   <= c_s1;
      d_s1   <= PS2D;
      d_s2   <= d_s1;
      fclk_d <= fclk;
      if (c_s2 == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FLIM) begin
        fclk <= c_s2;
        fcnt <= '0;
      end else if (fcnt != '1) begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fe   = fclk_d & ~fclk;
  assign BUSY = (state != st_idle);

  // Next-state logic; the inter-edge timeout overrides any edge seen in the same cycle
  always_comb begin
    next_state = state;
    bad        = 1'b0;
    tmo        = (state != st_idle) && (state != st_done) && (tcnt == TLIM);
    if (tmo) begin
      next_state = st_idle;
    end else begin
      case (state)
        st_idle:   if (fe && !d_s2) next_state = st_data;
        st_data:   if (fe && bitcnt == 3'd7) next_state = st_parity;
        st_parity: if (fe) next_state = st_stop;
        st_stop: begin
          if (fe) begin
            if (d_s2 && (^{shreg, par})) begin
              next_state = st_done;
            end else begin
              next_state = st_idle;
              bad        = 1'b1;
            end
          end
        end
        st_done:   next_state = st_idle;
        default:   next_state = st_idle;
      endcase
    end
    accept = (state == st_stop) && (next_state == st_done);
  end

  // Frame datapath, timeout counter and event outputs; event registers load on the stop edge so VALID lands in the DONE cycle
  always_ff @(posedge C) begin
    if (RST) begin
      state    <= st_idle;
      shreg    <= 8'h00;
      bitcnt   <= 3'd0;
      par      <= 1'b0;
      tcnt     <= '0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      CODE     <= 8'h00;
      VALID    <= 1'b0;
      BRK      <= 1'b0;
      EXT      <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state <= next_state;
      VALID <= 1'b0;
      ERR   <= 1'b0;

      if (fe || state == st_idle || state == st_done) begin
        tcnt <= '0;
      end else if (tcnt != TLIM) begin
        tcnt <= tcnt + 1'b1;
      end

      if (fe && !tmo) begin
        case (state)
          st_idle:   bitcnt <= 3'd0;
          st_data: begin
            shreg  <= {d_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          st_parity: par <= d_s2;
          default:   ;
        endcase
      end

      if (tmo || bad) begin
        ERR      <= 1'b1;
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else if (accept) begin
        if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else begin
          CODE     <= shreg;
          BRK      <= brk_pend;
          EXT      <= ext_pend;
          VALID    <= 1'b1;
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb/tb_ps2_rx_ctrl.sv - scoreboard testbench for ps2_rx_ctrl
module tb_ps2_rx_ctrl;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 40;

  logic       C = 1'b0;
  logic       RST = 1'b1;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic [7:0] CODE;
  logic       VALID, BRK, EXT, ERR, BUSY;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       busy;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  int last_fall = 0;
  bit prev_v = 0;
  bit prev_e = 0;

  bit         m_brk = 0;
  bit         m_ext = 0;
  logic [7:0] m_code = 8'h00;

  ps2_rx_ctrl #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .C(C), .RST(RST), .PS2C(PS2C), .PS2D(PS2D),
    .CODE(CODE), .VALID(VALID), .BRK(BRK), .EXT(EXT), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 C = ~C;

  always @(posedge C) cyc++;

  // Collect every VALID/ERR pulse seen away from the clock edge
  always @(negedge C) begin
    if (RST) begin
      prev_v = 0;
      prev_e = 0;
    end else begin
      if (VALID && ERR) both_cnt++;
      if ((VALID && prev_v) || (ERR && prev_e)) long_cnt++;
      if (VALID || ERR) obs_q.push_back('{ERR, CODE, BRK, EXT, BUSY, cyc});
      prev_v = VALID;
      prev_e = ERR;
    end
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    PS2D = b;
    repeat (HALF / 2) @(negedge C);
    PS2C = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge C);
    PS2C = 1'b1;
    repeat (HALF / 2) @(negedge C);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad);
    logic p;
    p = (~^d) ^ par_flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(~stop_bad);
    if (par_flip || stop_bad) begin
      exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0});
      m_brk = 0;
      m_ext = 0;
    end else if (d == 8'hF0) begin
      m_brk = 1;
    end else if (d == 8'hE0) begin
      m_ext = 1;
    end else begin
      exp_q.push_back('{1'b0, d, m_brk, m_ext, 1'b1, 0});
      m_code = d;
      m_brk  = 0;
      m_ext  = 0;
    end
    repeat (10) @(negedge C);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (5) @(negedge C);
    n_cmp++;
    if ({CODE, VALID, BRK, EXT, ERR, BUSY} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want 0000", {CODE, VALID, BRK, EXT, ERR, BUSY});
    end
    RST = 1'b0;
    repeat (5) @(negedge C);
  endtask

  task automatic test_single_frame();
    ev_t e, o;
    send_frame(8'h1C, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL single_frame: no event, want err=%0b code=%02h brk=%0b ext=%0b", e.is_err, e.code, e.brk, e.ext);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || (!e.is_err && {o.code, o.brk, o.ext} !== {e.code, e.brk, e.ext})) begin
          n_bad++;
          $display("FAIL single_frame: got err=%0b code=%02h brk=%0b ext=%0b, want err=%0b code=%02h brk=%0b ext=%0b",
                   o.is_err, o.code, o.brk, o.ext, e.is_err, e.code, e.brk, e.ext);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL single_frame_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_prefix();
    ev_t e, o;
    send_frame(8'hF0, 0, 0);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL prefix_f0_silent: got %0d events after F0, want 0", obs_q.size());
    end
    send_frame(8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL prefix: no event, want err=%0b code=%02h brk=%0b ext=%0b", e.is_err, e.code, e.brk, e.ext);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || (!e.is_err && {o.code, o.brk, o.ext} !== {e.code, e.brk, e.ext})) begin
          n_bad++;
          $display("FAIL prefix: got err=%0b code=%02h brk=%0b ext=%0b, want err=%0b code=%02h brk=%0b ext=%0b",
                   o.is_err, o.code, o.brk, o.ext, e.is_err, e.code, e.brk, e.ext);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL prefix_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_errors();
    ev_t e, o;
    send_frame(8'h1C, 1, 0);
    n_cmp++;
    if (CODE !== m_code) begin
      n_bad++;
      $display("FAIL parity_code_hold: got CODE=%02h, want %02h", CODE, m_code);
    end
    send_frame(8'h1C, 0, 1);
    n_cmp++;
    if (CODE !== m_code) begin
      n_bad++;
      $display("FAIL stop_code_hold: got CODE=%02h, want %02h", CODE, m_code);
    end
    send_frame(8'hF0, 0, 0);
    send_frame(8'h5A, 1, 0);
    send_frame(8'h1C, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL errors: no event, want err=%0b code=%02h brk=%0b ext=%0b", e.is_err, e.code, e.brk, e.ext);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || (!e.is_err && {o.code, o.brk, o.ext} !== {e.code, e.brk, e.ext})) begin
          n_bad++;
          $display("FAIL errors: got err=%0b code=%02h brk=%0b ext=%0b, want err=%0b code=%02h brk=%0b ext=%0b",
                   o.is_err, o.code, o.brk, o.ext, e.is_err, e.code, e.brk, e.ext);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL errors_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    ev_t e, o;
    int k;
    int lo, hi;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0});
    m_brk = 0;
    m_ext = 0;
    k = 0;
    while (obs_q.size() == 0 && k < 1300) begin
      @(negedge C);
      k++;
    end
    e = exp_q.pop_front();
    lo = last_fall + FILTER + TIMEOUT;
    hi = last_fall + FILTER + TIMEOUT + 6;
    n_cmp++;
    if (obs_q.size() == 0) begin
      n_bad++;
      $display("FAIL timeout_err: no ERR within 1300 cycles, want ERR near cycle %0d", lo + 3);
    end else begin
      o = obs_q.pop_front();
      if (o.is_err !== e.is_err || o.cyc < lo || o.cyc > hi || o.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_err: got err=%0b cycle=%0d busy=%0b, want err=1 cycle in [%0d,%0d] busy=0",
                 o.is_err, o.cyc, o.busy, lo, hi);
      end
    end
    repeat (20) @(negedge C);
    send_frame(8'h29, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL timeout_recover: no event, want code=%02h", e.code);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || {o.code, o.brk, o.ext} !== {e.code, e.brk, e.ext}) begin
          n_bad++;
          $display("FAIL timeout_recover: got err=%0b code=%02h brk=%0b ext=%0b, want err=0 code=%02h brk=%0b ext=%0b",
                   o.is_err, o.code, o.brk, o.ext, e.code, e.brk, e.ext);
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit busy_seen;
    busy_seen = 0;
    for (int g = 0; g < 5; g++) begin
      PS2C = 1'b0;
      repeat (3) @(negedge C);
      PS2C = 1'b1;
      for (int w = 0; w < 25; w++) begin
        @(negedge C);
        if (BUSY) busy_seen = 1;
      end
    end
    n_cmp++;
    if (busy_seen !== 1'b0 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL glitch_ignored: got busy_seen=%0b events=%0d, want busy_seen=0 events=0", busy_seen, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    ev_t e, o;
    send_frame(8'hF0, 0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    RST = 1'b1;
    @(negedge C);
    n_cmp++;
    if ({CODE, VALID, BRK, EXT, ERR, BUSY} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_midframe_outputs: got %h, want 0000", {CODE, VALID, BRK, EXT, ERR, BUSY});
    end
    RST = 1'b0;
    m_brk  = 0;
    m_ext  = 0;
    m_code = 8'h00;
    repeat (20) @(negedge C);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_midframe_silent: got %0d events, want 0", obs_q.size());
      obs_q.delete();
    end
    send_frame(8'h29, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL reset_recover: no event, want code=%02h", e.code);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || {o.code, o.brk, o.ext} !== {e.code, e.brk, e.ext}) begin
          n_bad++;
          $display("FAIL reset_recover: got err=%0b code=%02h brk=%0b ext=%0b, want err=0 code=%02h brk=%0b ext=%0b",
                   o.is_err, o.code, o.brk, o.ext, e.code, e.brk, e.ext);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'h29, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL back_to_back: no event, want code=%02h brk=%0b ext=%0b", e.code, e.brk, e.ext);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || {o.code, o.brk, o.ext} !== {e.code, e.brk, e.ext}) begin
          n_bad++;
          $display("FAIL back_to_back: got err=%0b code=%02h brk=%0b ext=%0b, want err=0 code=%02h brk=%0b ext=%0b",
                   o.is_err, o.code, o.brk, o.ext, e.code, e.brk, e.ext);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL back_to_back_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
    n_cmp++;
    if (both_cnt != 0 || long_cnt != 0) begin
      n_bad++;
      $display("FAIL pulse_shape: got overlap=%0d long=%0d, want 0 and 0", both_cnt, long_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_prefix();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
